// File: rtl/mul_dispatcher.sv
// Upstream feeder for the one-hot multiply sequencer: buffers tagged operand pairs,
// launches one multiply at a time and reports completion or timeout.
module mul_dispatcher #(
  parameter int BITS     = 8,
  parameter int DEPTH    = 4,
  parameter int TAG_BITS = 4,
  parameter int TIMEOUT  = 32
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [BITS-1:0]        i_multiplier,
  input  logic [BITS-1:0]        i_multiplicand,
  input  logic [TAG_BITS-1:0]    i_tag,
  output logic                   o_start,
  input  logic                   i_finished,
  output logic [BITS-1:0]        o_multiplier,
  output logic [BITS-1:0]        o_multiplicand,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [TAG_BITS-1:0]    o_done_tag,
  output logic                   o_timeout,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    BUSY
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [BITS-1:0]     r_memA   [DEPTH];
  logic [BITS-1:0]     r_memB   [DEPTH];
  logic [TAG_BITS-1:0] r_memTag [DEPTH];

  logic [AW-1:0]       r_wrPtr;
  logic [AW-1:0]       r_rdPtr;
  logic [AW:0]         r_count;
  logic [CW-1:0]       r_timer;
  logic                r_done;
  logic                r_timeout;
  logic [BITS-1:0]     r_multiplier;
  logic [BITS-1:0]     r_multiplicand;
  logic [TAG_BITS-1:0] r_tag;

  logic w_push;
  logic w_pop;
  logic w_start;
  logic w_finishOk;
  logic w_expire;

  // Ready depends only on the registered count, so a full FIFO refuses a push even while popping.
  assign o_ready = (r_count != (AW+1)'(DEPTH));
  assign w_push  = i_valid & o_ready;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_pop       = 1'b0;
    w_start     = 1'b0;
    w_finishOk  = 1'b0;
    w_expire    = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_nextState = LAUNCH;
        end
      end
      LAUNCH: begin
        w_start     = 1'b1;
        w_nextState = BUSY;
      end
      BUSY: begin
        if (i_finished) begin
          w_finishOk  = 1'b1;
          w_nextState = IDLE;
        end else if (r_timer == CW'(TIMEOUT - 1)) begin
          w_expire    = 1'b1;
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (w_push) begin
      r_memA[r_wrPtr]   <= i_multiplier;
      r_memB[r_wrPtr]   <= i_multiplicand;
      r_memTag[r_wrPtr] <= i_tag;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Operands and tag stay stable from the pop until the next pop, covering the o_done cycle.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_multiplier   <= '0;
      r_multiplicand <= '0;
      r_tag          <= '0;
    end else if (w_pop) begin
      r_multiplier   <= r_memA[r_rdPtr];
      r_multiplicand <= r_memB[r_rdPtr];
      r_tag          <= r_memTag[r_rdPtr];
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_timer <= '0;
    end else if (r_state == LAUNCH) begin
      r_timer <= '0;
    end else if (r_state == BUSY) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_done    <= w_finishOk;
      r_timeout <= r_timeout | w_expire;
    end
  end

  assign o_start        = w_start;
  assign o_busy         = (r_state != IDLE);
  assign o_done         = r_done;
  assign o_done_tag     = r_tag;
  assign o_timeout      = r_timeout;
  assign o_multiplier   = r_multiplier;
  assign o_multiplicand = r_multiplicand;
  assign o_count        = r_count;

endmodule

// File: tb/tb_mul_dispatcher.sv
// Self-checking bench for mul_dispatcher: directed scenarios followed by random traffic,
// checked every cycle against a timing-rule model of queued jobs.
module tb_mul_dispatcher;

  localparam int BITS     = 8;
  localparam int DEPTH    = 4;
  localparam int TAG_BITS = 4;
  localparam int TIMEOUT  = 32;
  localparam int CNTW     = $clog2(DEPTH) + 1;

  logic                i_clock = 1'b0;
  logic                i_reset;
  logic                i_valid;
  logic                o_ready;
  logic [BITS-1:0]     i_multiplier;
  logic [BITS-1:0]     i_multiplicand;
  logic [TAG_BITS-1:0] i_tag;
  logic                o_start;
  logic                i_finished;
  logic [BITS-1:0]     o_multiplier;
  logic [BITS-1:0]     o_multiplicand;
  logic                o_busy;
  logic                o_done;
  logic [TAG_BITS-1:0] o_done_tag;
  logic                o_timeout;
  logic [CNTW-1:0]     o_count;

  mul_dispatcher #(
    .BITS(BITS), .DEPTH(DEPTH), .TAG_BITS(TAG_BITS), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_multiplier(i_multiplier), .i_multiplicand(i_multiplicand), .i_tag(i_tag),
    .o_start(o_start), .i_finished(i_finished), .o_multiplier(o_multiplier),
    .o_multiplicand(o_multiplicand), .o_busy(o_busy), .o_done(o_done),
    .o_done_tag(o_done_tag), .o_timeout(o_timeout), .o_count(o_count)
  );

  always #5 i_clock = ~i_clock;

  // A job's whole life is derived from when it was accepted and its finished latency:
  // start = max(push+2, previous end+2); busy from start to end; done or timeout at end+1.
  typedef struct {
    int                  push;
    int                  start;
    int                  last;
    int                  lat;
    bit                  fin;
    logic [BITS-1:0]     a;
    logic [BITS-1:0]     b;
    logic [TAG_BITS-1:0] tag;
  } job_t;

  job_t jobs[$];
  job_t srcQ[$];
  int   cyc;
  int   vectors;
  int   miscompares;
  bit   strayReq;

  function automatic job_t mk(int a, int b, int tag, int lat);
    job_t j;
    j.push  = 0;
    j.start = 0;
    j.last  = 0;
    j.fin   = 1'b0;
    j.lat   = lat;
    j.a     = BITS'(a);
    j.b     = BITS'(b);
    j.tag   = TAG_BITS'(tag);
    return j;
  endfunction

  function automatic int randLat();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 8) return TIMEOUT - 1;
    if (r == 9) return TIMEOUT + 3;
    return int'($urandom_range(0, 10));
  endfunction

  function automatic int mCount(int t);
    int c;
    c = 0;
    foreach (jobs[i]) begin
      if (jobs[i].push < t) c++;
      if (jobs[i].start <= t) c--;
    end
    return c;
  endfunction

  function automatic bit mInBusy(int t);
    bit r;
    r = 1'b0;
    foreach (jobs[i]) begin
      if (jobs[i].start + 1 <= t && t <= jobs[i].last) r = 1'b1;
    end
    return r;
  endfunction

  task automatic addJob(job_t j, int t);
    int prevEnd;
    prevEnd = (jobs.size() != 0) ? jobs[jobs.size()-1].last : -100;
    j.push  = t;
    j.start = (t + 2 > prevEnd + 2) ? t + 2 : prevEnd + 2;
    j.fin   = (j.lat <= TIMEOUT - 1);
    j.last  = j.start + 1 + (j.fin ? j.lat : TIMEOUT - 1);
    jobs.push_back(j);
  endtask

  task automatic compare(string name, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s at cycle %0d: observed %0h expected %0h", name, cyc, obs, exp);
    end
  endtask

  // Drives the inputs for the current cycle: the source offers its head job until accepted,
  // and the sequencer model raises finished at each job's planned latency.
  task automatic applyStimulus();
    bit due;
    due = 1'b0;
    foreach (jobs[i]) begin
      if (jobs[i].fin && jobs[i].start + 1 + jobs[i].lat == cyc) due = 1'b1;
    end
    i_finished     = due || (strayReq && !mInBusy(cyc));
    strayReq       = 1'b0;
    i_valid        = 1'b0;
    i_multiplier   = BITS'($urandom);
    i_multiplicand = BITS'($urandom);
    i_tag          = TAG_BITS'($urandom);
    if (srcQ.size() != 0) begin
      i_valid        = 1'b1;
      i_multiplier   = srcQ[0].a;
      i_multiplicand = srcQ[0].b;
      i_tag          = srcQ[0].tag;
      if (mCount(cyc) != DEPTH) begin
        addJob(srcQ[0], cyc);
        void'(srcQ.pop_front());
      end
    end
  endtask

  // Compares every output against the job model for the current cycle.
  task automatic checkOutput();
    int                  cnt;
    bit                  eStart, eBusy, eDone, eTo;
    logic [BITS-1:0]     eA, eB;
    logic [TAG_BITS-1:0] eTag;
    cnt    = mCount(cyc);
    eStart = 1'b0;
    eBusy  = 1'b0;
    eDone  = 1'b0;
    eTo    = 1'b0;
    eA     = '0;
    eB     = '0;
    eTag   = '0;
    foreach (jobs[i]) begin
      if (jobs[i].start == cyc) eStart = 1'b1;
      if (jobs[i].start <= cyc && cyc <= jobs[i].last) eBusy = 1'b1;
      if (jobs[i].fin && jobs[i].last + 1 == cyc) eDone = 1'b1;
      if (!jobs[i].fin && jobs[i].last + 1 <= cyc) eTo = 1'b1;
      if (jobs[i].start <= cyc) begin
        eA   = jobs[i].a;
        eB   = jobs[i].b;
        eTag = jobs[i].tag;
      end
    end
    compare("count",    32'(o_count),        32'(cnt));
    compare("ready",    32'(o_ready),        32'(cnt != DEPTH));
    compare("start",    32'(o_start),        32'(eStart));
    compare("busy",     32'(o_busy),         32'(eBusy));
    compare("done",     32'(o_done),         32'(eDone));
    compare("done_tag", 32'(o_done_tag),     32'(eTag));
    compare("timeout",  32'(o_timeout),      32'(eTo));
    compare("mult_a",   32'(o_multiplier),   32'(eA));
    compare("mult_b",   32'(o_multiplicand), 32'(eB));
  endtask

  task automatic stepCycle();
    @(posedge i_clock);
    #1;
    cyc++;
    checkOutput();
  endtask

  task automatic runCycles(int n);
    repeat (n) begin
      applyStimulus();
      stepCycle();
    end
  endtask

  task automatic runUntil(int target);
    while (cyc < target) begin
      applyStimulus();
      stepCycle();
    end
  endtask

  task automatic rstCheck();
    compare("rst_ready",   32'(o_ready),        32'(1));
    compare("rst_start",   32'(o_start),        32'(0));
    compare("rst_busy",    32'(o_busy),         32'(0));
    compare("rst_done",    32'(o_done),         32'(0));
    compare("rst_tag",     32'(o_done_tag),     32'(0));
    compare("rst_timeout", 32'(o_timeout),      32'(0));
    compare("rst_count",   32'(o_count),        32'(0));
    compare("rst_mult_a",  32'(o_multiplier),   32'(0));
    compare("rst_mult_b",  32'(o_multiplicand), 32'(0));
  endtask

  // Raises reset mid-cycle, checks outputs before any clock edge, then releases after one edge.
  task automatic doAsyncReset();
    i_valid    = 1'b0;
    i_finished = 1'b0;
    #2;
    i_reset = 1'b1;
    #1;
    rstCheck();
    @(posedge i_clock);
    #1;
    cyc++;
    i_reset = 1'b0;
    jobs.delete();
    srcQ.delete();
    checkOutput();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int guard;
    vectors        = 0;
    miscompares    = 0;
    strayReq       = 1'b0;
    cyc            = 0;
    i_reset        = 1'b1;
    i_valid        = 1'b0;
    i_finished     = 1'b0;
    i_multiplier   = '0;
    i_multiplicand = '0;
    i_tag          = '0;
    #1;
    rstCheck();
    @(posedge i_clock);
    #1;
    i_reset = 1'b0;
    checkOutput();

    $display("[TB] single job");
    srcQ.push_back(mk(5, 7, 3, 7));
    runCycles(16);

    $display("[TB] fill and back-pressure");
    for (int k = 0; k < 6; k++) srcQ.push_back(mk(16 + k, 32 + k, k, 12));
    runCycles(105);

    $display("[TB] simultaneous push and pop");
    srcQ.push_back(mk(1, 2, 9, 3));
    srcQ.push_back(mk(3, 4, 10, 3));
    runCycles(2);
    runUntil(jobs[jobs.size()-1].start - 1);
    srcQ.push_back(mk(5, 6, 11, 2));
    runCycles(20);

    $display("[TB] timeout then next job");
    srcQ.push_back(mk(200, 100, 12, TIMEOUT + 8));
    srcQ.push_back(mk(17, 19, 13, 4));
    runCycles(50);

    $display("[TB] finished on last timer cycle, stray finished in idle");
    srcQ.push_back(mk(99, 98, 14, TIMEOUT - 1));
    runCycles(40);
    strayReq = 1'b1;
    runCycles(5);

    $display("[TB] async reset mid-busy");
    for (int k = 0; k < 3; k++) srcQ.push_back(mk(40 + k, 50 + k, 5 + k, 25));
    runCycles(8);
    compare("pre_rst_count", 32'(o_count), 32'(2));
    doAsyncReset();
    runCycles(30);

    $display("[TB] random traffic");
    for (int k = 0; k < 250; k++) begin
      if (srcQ.size() < 3 && $urandom_range(0, 99) < 35)
        srcQ.push_back(mk(int'($urandom), int'($urandom), int'($urandom), randLat()));
      if ($urandom_range(0, 9) == 0) strayReq = 1'b1;
      applyStimulus();
      stepCycle();
    end
    guard = 0;
    while (guard < 600 && (srcQ.size() != 0 ||
           (jobs.size() != 0 && jobs[jobs.size()-1].last + 2 > cyc))) begin
      applyStimulus();
      stepCycle();
      guard++;
    end
    vectors++;
    if (guard >= 600) begin
      miscompares++;
      $error("[TB] FAIL drain: observed still pending after %0d cycles, expected idle", guard);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
